// File: rtl/systolic_array_ctrl.sv
// Sequencing controller for the NxN systolic-array multiplier: accepts a
//    request, pulses operand capture and accumulator clear, drives the skew
//    feeders for STEPS cycles, then holds the result until it is consumed.
// Latency: accept at cycle t -> o_shiftEn high t+1..t+STEPS -> o_validResult
//    from t+STEPS+1. Backpressure: o_validResult is held while i_resultReady is
//    low; o_ready is low during streaming and while an unconsumed result is held.
// Ports:
//    i_clk, i_arst        clock (rising edge), asynchronous active-high reset
//    i_validInput/o_ready request handshake; o_loadInputs/o_peClear = accept
//    o_shiftEn, o_step    feeder advance and current stream cycle index
//    o_busy               high while streaming or holding a result
//    o_validResult        result handshake with i_resultReady
//    i_flush              synchronous abort, highest priority
module systolic_array_ctrl #(
   parameter int N = 4
) (
   input  logic                               i_clk,
   input  logic                               i_arst,
   input  logic                               i_validInput,
   output logic                               o_ready,
   output logic                               o_loadInputs,
   output logic                               o_peClear,
   output logic                               o_shiftEn,
   output logic [$clog2(3*N-2)-1:0]           o_step,
   output logic                               o_busy,
   output logic                               o_validResult,
   input  logic                               i_resultReady,
   input  logic                               i_flush
);

   // The last PE (N-1,N-1) sees its final operand pair after 3N-2 shifts.
   localparam int STEPS = 3*N - 2;
   localparam int CW    = $clog2(STEPS);
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            accept;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Ready in DONE only when the consumer takes the result this same cycle,
   // which lets a new request start with no idle bubble.
   always_comb begin
      o_ready = (state_q == IDLE) || ((state_q == DONE) && i_resultReady);
      accept  = i_validInput && o_ready && !i_flush;
   end

   assign o_loadInputs = accept;
   assign o_peClear    = accept;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (i_flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST_STEP) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            cnt_d = '0;
            if (i_flush) begin
               state_d = IDLE;
            end else if (accept) begin
               state_d = STREAM;
            end else if (i_resultReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered-state outputs only; no input reaches these.
   always_comb begin
      o_shiftEn     = (state_q == STREAM);
      o_busy        = (state_q == STREAM) || (state_q == DONE);
      o_validResult = (state_q == DONE);
      o_step        = (state_q == STREAM) ? cnt_q : '0;
   end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
module tb_systolic_array_ctrl;

   localparam int N     = 4;
   localparam int STEPS = 10;   // 3*4-2, hand-computed

   logic       i_clk;
   logic       i_arst;
   logic       i_validInput;
   logic       o_ready;
   logic       o_loadInputs;
   logic       o_peClear;
   logic       o_shiftEn;
   logic [3:0] o_step;
   logic       o_busy;
   logic       o_validResult;
   logic       i_resultReady;
   logic       i_flush;

   int checks   = 0;
   int failures = 0;

   systolic_array_ctrl #(.N(N)) dut (
      .i_clk         (i_clk),
      .i_arst        (i_arst),
      .i_validInput  (i_validInput),
      .o_ready       (o_ready),
      .o_loadInputs  (o_loadInputs),
      .o_peClear     (o_peClear),
      .o_shiftEn     (o_shiftEn),
      .o_step        (o_step),
      .o_busy        (o_busy),
      .o_validResult (o_validResult),
      .i_resultReady (i_resultReady),
      .i_flush       (i_flush)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Issue a request from IDLE; this cycle is "t".
   task automatic request();
      tick();
      i_validInput  = 1'b1;
      i_resultReady = 1'b0;
      i_flush       = 1'b0;
      #1;
      check("acc_ready", o_ready, 1);
      check("acc_load", o_loadInputs, 1);
      check("acc_clear", o_peClear, 1);
   endtask

   // Check stream cycles t+1.. ; optionally pulse valid at one step or flush at one step.
   task automatic stream_checks(input int pulse_at, input int flush_at);
      for (int k = 0; k < STEPS; k++) begin
         tick();
         i_validInput  = (k == pulse_at);
         i_flush       = (k == flush_at);
         i_resultReady = 1'b0;
         #1;
         check("st_shift", o_shiftEn, 1);
         check("st_step", o_step, k);
         check("st_busy", o_busy, 1);
         check("st_ready", o_ready, 0);
         check("st_vres", o_validResult, 0);
         check("st_load", o_loadInputs, 0);
         if (k == flush_at) break;
      end
   endtask

   // First DONE cycle, consumer not ready.
   task automatic done_check();
      tick();
      i_validInput  = 1'b0;
      i_flush       = 1'b0;
      i_resultReady = 1'b0;
      #1;
      check("dn_vres", o_validResult, 1);
      check("dn_shift", o_shiftEn, 0);
      check("dn_busy", o_busy, 1);
      check("dn_ready", o_ready, 0);
      check("dn_step", o_step, 0);
   endtask

   // Consume the result without a new request; expect IDLE next cycle.
   task automatic consume();
      tick();
      i_resultReady = 1'b1;
      i_validInput  = 1'b0;
      #1;
      check("cons_ready", o_ready, 1);
      check("cons_load", o_loadInputs, 0);
      tick();
      i_resultReady = 1'b0;
      #1;
      check("idle_vres", o_validResult, 0);
      check("idle_busy", o_busy, 0);
      check("idle_ready", o_ready, 1);
   endtask

   initial begin
      i_arst        = 1'b1;
      i_validInput  = 1'b0;
      i_resultReady = 1'b0;
      i_flush       = 1'b0;
      #2;
      check("rst_ready", o_ready, 1);
      check("rst_shift", o_shiftEn, 0);
      check("rst_busy", o_busy, 0);
      check("rst_vres", o_validResult, 0);
      check("rst_step", o_step, 0);
      #10 i_arst = 1'b0;

      // Basic sequence with held result.
      request();
      stream_checks(-1, -1);
      done_check();
      for (int h = 0; h < 3; h++) begin
         tick();
         i_validInput = 1'b1;   // a request while holding must not be taken
         #1;
         check("hold_vres", o_validResult, 1);
         check("hold_load", o_loadInputs, 0);
      end
      i_validInput = 1'b0;
      consume();

      // Back-to-back: consume and accept in the same DONE cycle; also a
      // valid pulse at step 4 that must be ignored.
      request();
      stream_checks(-1, -1);
      done_check();
      tick();
      i_resultReady = 1'b1;
      i_validInput  = 1'b1;
      #1;
      check("b2b_ready", o_ready, 1);
      check("b2b_load", o_loadInputs, 1);
      check("b2b_clear", o_peClear, 1);
      stream_checks(4, -1);
      done_check();
      consume();

      // Flush in IDLE blocks accept.
      tick();
      i_validInput = 1'b1;
      i_flush      = 1'b1;
      #1;
      check("fidle_load", o_loadInputs, 0);
      tick();
      i_validInput = 1'b0;
      i_flush      = 1'b0;
      #1;
      check("fidle_shift", o_shiftEn, 0);
      check("fidle_busy", o_busy, 0);

      // Flush at step 6: back to IDLE, result never valid.
      request();
      stream_checks(-1, 6);
      tick();
      i_flush      = 1'b0;
      i_validInput = 1'b0;
      #1;
      check("fl_shift", o_shiftEn, 0);
      check("fl_busy", o_busy, 0);
      check("fl_ready", o_ready, 1);
      check("fl_step", o_step, 0);
      for (int w = 0; w < 6; w++) begin
         tick();
         #1;
         check("fl_novres", o_validResult, 0);
      end
      request();
      stream_checks(-1, -1);
      done_check();

      // Flush in DONE drops the result.
      tick();
      i_flush = 1'b1;
      #1;
      check("fdone_ready", o_ready, 0);
      tick();
      i_flush = 1'b0;
      #1;
      check("fdone_vres", o_validResult, 0);
      check("fdone_busy", o_busy, 0);

      // Asynchronous reset mid-stream.
      request();
      stream_checks(-1, 3);   // flush_at used only to stop the loop at step 3
      i_flush = 1'b0;
      #2;
      i_arst = 1'b1;
      #1;
      check("arst_shift", o_shiftEn, 0);
      check("arst_busy", o_busy, 0);
      check("arst_step", o_step, 0);
      check("arst_ready", o_ready, 1);
      tick();
      #1;
      check("arst_hold_shift", o_shiftEn, 0);
      #2 i_arst = 1'b0;
      request();
      stream_checks(-1, -1);
      done_check();
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencing controller for the 4x4 8-bit systolic-array multiplier.
- Accepts a multiply request with a valid/ready handshake, pulses the capture and accumulator-clear enables, then drives the shift enable for the skewed row/column feeders for exactly the number of cycles the array needs.
- Holds the result valid until the consumer accepts it.
- Sits between the host interface and the input registers, skew feeders and PE grid.

Parameters:
- N, 4: array dimension (rows = columns); legal N >= 2.
- STEPS, 3*N-2: stream cycles needed for the last PE (N-1,N-1) to consume its final operand pair; derived, not overridden.
- CW, $clog2(STEPS): width of step counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_arst  input  1  asynchronous active-high reset.
- i_validInput  input  1  request: operands on the host bus are valid.
- o_ready  output  1  controller can accept a request this cycle (combinational).
- o_loadInputs  output  1  capture enable for the operand registers (combinational, = accept).
- o_peClear  output  1  synchronous clear for all PE accumulators (combinational, = accept).
- o_shiftEn  output  1  advance row/column skew feeders and PE pipelines.
- o_step  output  CW  index of the current stream cycle, 0..STEPS-1; 0 outside STREAM.
- o_busy  output  1  high in STREAM or DONE.
- o_validResult  output  1  PE accumulators hold the final product.
- i_resultReady  input  1  consumer accepts the result.
- i_flush  input  1  synchronous abort.

Behaviour:
- States: IDLE, STREAM, DONE. Encoding free; state and counter registered, async reset.
- Reset (asserted at any time, including mid-operation): state = IDLE, counter = 0 immediately. Registered outputs go low: o_shiftEn, o_busy, o_validResult, o_step = 0. o_ready = 1 while in reset, since IDLE is forced.
- o_ready = (state==IDLE) | (state==DONE & i_resultReady). Never asserted in STREAM.
- accept = i_validInput & o_ready & ~i_flush. o_loadInputs = o_peClear = accept, in the same cycle, so operands and clear take effect at the accept edge.
- IDLE: on accept go to STREAM with counter = 0. Otherwise stay. i_validInput low, or i_flush high, keeps IDLE.
- STREAM:
  - o_shiftEn = 1, o_busy = 1, o_step = counter.
  - counter increments each cycle.
  - When counter == STEPS-1, next state is DONE and the counter resets to 0.
  - i_validInput is ignored (no accept).
- DONE:
  - o_validResult = 1, o_busy = 1, o_shiftEn = 0.
  - o_validResult is held while i_resultReady is low.
  - i_resultReady without a new accept: go to IDLE.
  - i_resultReady with accept in the same cycle: go straight to STREAM (back-to-back, no idle bubble).
- i_flush: highest priority. From STREAM or DONE, next state is IDLE and the counter is cleared. o_validResult is never raised for a flushed operation. i_flush in IDLE blocks accept.
- Latency: accept at cycle t. o_shiftEn is high in cycles t+1..t+STEPS. o_validResult first goes high in cycle t+STEPS+1 (N=4: 10 shift cycles, valid at t+11).
- Throughput: one multiply per STEPS+1 cycles with a consumer that is always ready.
- Outputs o_shiftEn, o_busy, o_validResult and o_step are pure functions of registered state (no input-to-output paths). o_ready, o_loadInputs and o_peClear are the only combinational outputs.

Test Plan:
- Reset then i_validInput = 1 for 1 cycle at t, i_resultReady = 0 → o_loadInputs = o_peClear = 1 at t. o_shiftEn high t+1..t+10 with o_step 0..9. o_validResult high from t+11 and held; o_ready = 0 from t+1.
- In DONE, assert i_resultReady = 1 at cycle d → o_ready = 1 at d, state IDLE at d+1, o_validResult = 0 at d+1.
- i_resultReady = 1 and i_validInput = 1 in the same DONE cycle d → o_loadInputs = 1 at d, o_shiftEn = 1 at d+1 with o_step = 0, no IDLE cycle.
- i_validInput pulsed during STREAM (o_step = 4) → o_loadInputs stays 0, o_step continues 5..9 undisturbed.
- i_flush = 1 at o_step = 6 → IDLE next cycle, o_shiftEn = 0, o_validResult never asserts. A new request 1 cycle later completes normally.
- i_arst pulsed asynchronously mid-STREAM (between edges) → o_shiftEn and o_busy drop immediately, o_step = 0, o_ready = 1. The first request after deassert yields the full 10-cycle sequence.
